// File: rtl/player_ctrl.sv
// Player cannon position/aim controller: synchronised buttons, hold auto-repeat, aim vector and fire handshake.
// Optional build macro WRAP_X_EN makes x_pos wrap between X_MIN and X_MAX instead of saturating.
module player_ctrl #(
  parameter int X_W         = 5,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 31,
  parameter int X_INIT      = 15,
  parameter int AIM_W       = 3,
  parameter int VEC_W       = 5,
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_x,
  input  logic             right_x,
  input  logic             left_aim,
  input  logic             right_aim,
  input  logic             fire,
  input  logic             shot_ready,
  output logic [X_W-1:0]   x_pos,
  output logic [AIM_W-1:0] aim_pos,
  output logic [VEC_W-1:0] run,
  output logic [VEC_W-1:0] rise,
  output logic             dir,
  output logic             shot_valid,
  output logic [X_W-1:0]   shot_x,
  output logic [AIM_W-1:0] shot_aim
);
  localparam int HALF  = 1 << (AIM_W - 1);
  localparam int SH    = VEC_W - AIM_W;
  localparam int RMAX  = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CNT_W = $clog2(RMAX + 1);
  localparam logic [X_W-1:0]   X_LO    = X_W'(X_MIN);
  localparam logic [X_W-1:0]   X_HI    = X_W'(X_MAX);
  localparam logic [AIM_W-1:0] AIM_TOP = '1;

  logic s_lx, s_rx, s_la, s_ra, s_f, p_f;
  logic [CNT_W-1:0] x_cnt, a_cnt;
  logic x_first, a_first;
  logic x_one, a_one, x_step, a_step, fire_press;
  logic [X_W-1:0]   x_next;
  logic [AIM_W-1:0] aim_next, m;

  // An axis steps when exactly one of its buttons is held and the counter
  // is at 0 (start of a hold), at REPEAT_DLY, then every REPEAT_RATE cycles.
  assign x_one  = s_lx ^ s_rx;
  assign a_one  = s_la ^ s_ra;
  assign x_step = x_one & (x_first ? (x_cnt == '0 || x_cnt == CNT_W'(REPEAT_DLY))
                                   : (x_cnt == CNT_W'(REPEAT_RATE)));
  assign a_step = a_one & (a_first ? (a_cnt == '0 || a_cnt == CNT_W'(REPEAT_DLY))
                                   : (a_cnt == CNT_W'(REPEAT_RATE)));
  assign fire_press = s_f & ~p_f;

  always_comb begin
    x_next = x_pos;
    if (x_step) begin
      if (s_lx) begin
`ifdef WRAP_X_EN
        x_next = (x_pos == X_LO) ? X_HI : x_pos - X_W'(1);
`else
        x_next = (x_pos == X_LO) ? X_LO : x_pos - X_W'(1);
`endif
      end else begin
`ifdef WRAP_X_EN
        x_next = (x_pos == X_HI) ? X_LO : x_pos + X_W'(1);
`else
        x_next = (x_pos == X_HI) ? X_HI : x_pos + X_W'(1);
`endif
      end
    end
  end

  always_comb begin
    aim_next = aim_pos;
    if (a_step) begin
      if (s_la) aim_next = (aim_pos == '0) ? '0 : aim_pos - AIM_W'(1);
      else      aim_next = (aim_pos == AIM_TOP) ? AIM_TOP : aim_pos + AIM_W'(1);
    end
  end

  // Aim vector: m is the distance from the vertical centre line.
  always_comb begin
    dir  = (aim_pos >= AIM_W'(HALF));
    m    = dir ? aim_pos - AIM_W'(HALF) : AIM_W'(HALF - 1) - aim_pos;
    run  = (VEC_W'(m) + VEC_W'(1)) << SH;
    rise = (VEC_W'(HALF) - VEC_W'(m)) << SH;
  end

  // Shot handshake: shot_valid stays high with a stable snapshot until a cycle
  // with shot_ready high; it then drops, and a fire press in that cycle is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_lx <= 1'b0; s_rx <= 1'b0; s_la <= 1'b0; s_ra <= 1'b0;
      s_f  <= 1'b0; p_f  <= 1'b0;
      x_cnt <= '0; a_cnt <= '0; x_first <= 1'b1; a_first <= 1'b1;
      x_pos <= X_W'(X_INIT);
      aim_pos <= AIM_W'(HALF);
      shot_valid <= 1'b0;
      shot_x <= '0;
      shot_aim <= '0;
    end else begin
      s_lx <= left_x;   s_rx <= right_x;
      s_la <= left_aim; s_ra <= right_aim;
      s_f  <= fire;     p_f  <= s_f;

      if (!x_one) begin
        x_cnt <= '0; x_first <= 1'b1;
      end else if (x_step) begin
        x_cnt <= CNT_W'(1);
        if (x_cnt != '0) x_first <= 1'b0;
      end else begin
        x_cnt <= x_cnt + CNT_W'(1);
      end

      if (!a_one) begin
        a_cnt <= '0; a_first <= 1'b1;
      end else if (a_step) begin
        a_cnt <= CNT_W'(1);
        if (a_cnt != '0) a_first <= 1'b0;
      end else begin
        a_cnt <= a_cnt + CNT_W'(1);
      end

      x_pos   <= x_next;
      aim_pos <= aim_next;

      if (shot_valid && shot_ready) begin
        shot_valid <= 1'b0;
      end else if (!shot_valid && fire_press) begin
        shot_valid <= 1'b1;
        shot_x     <= x_pos;
        shot_aim   <= aim_pos;
      end
    end
  end
endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: stepping, auto-repeat, saturation, aim vector and shot handshake.
module tb_player_ctrl;
  logic clk = 1'b0;
  logic reset, left_x, right_x, left_aim, right_aim, fire, shot_ready;
  logic [4:0] x_pos, shot_x;
  logic [2:0] aim_pos, shot_aim;
  logic [4:0] run, rise;
  logic dir, shot_valid;
  int vectors = 0;
  int miscompares = 0;

  player_ctrl dut (
    .clk(clk), .reset(reset), .left_x(left_x), .right_x(right_x),
    .left_aim(left_aim), .right_aim(right_aim), .fire(fire), .shot_ready(shot_ready),
    .x_pos(x_pos), .aim_pos(aim_pos), .run(run), .rise(rise), .dir(dir),
    .shot_valid(shot_valid), .shot_x(shot_x), .shot_aim(shot_aim)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; left_x = 1'b0; right_x = 1'b0; left_aim = 1'b0; right_aim = 1'b0;
    fire = 1'b0; shot_ready = 1'b0;
    repeat (2) tick();
    chk("rst_x", 32'(x_pos), 15);
    chk("rst_aim", 32'(aim_pos), 4);
    chk("rst_valid", 32'(shot_valid), 0);
    chk("rst_shot_x", 32'(shot_x), 0);
    chk("rst_shot_aim", 32'(shot_aim), 0);
    chk("rst_run", 32'(run), 4);
    chk("rst_rise", 32'(rise), 16);
    chk("rst_dir", 32'(dir), 1);
    reset = 1'b0;

    // single-cycle tap: step lands two edges after the press
    right_x = 1'b1; tick(); right_x = 1'b0;
    chk("tap_edge1", 32'(x_pos), 15);
    tick();
    chk("tap_edge2", 32'(x_pos), 16);
    repeat (4) tick();
    chk("tap_hold", 32'(x_pos), 16);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_x", 32'(x_pos), 15);

    // 30-cycle hold: steps at hold counts 0,8,12,...,28
    left_x = 1'b1; repeat (2) tick();
    chk("rep_first", 32'(x_pos), 14);
    repeat (7) tick();
    chk("rep_cnt7", 32'(x_pos), 14);
    tick();
    chk("rep_cnt8", 32'(x_pos), 13);
    repeat (20) tick(); left_x = 1'b0; repeat (2) tick();
    chk("rep_final", 32'(x_pos), 8);

    // 40-cycle hold from 8: nine attempted steps, the last one past X_MIN
    left_x = 1'b1; repeat (40) tick(); left_x = 1'b0; repeat (2) tick();
`ifdef WRAP_X_EN
    chk("x_low_limit", 32'(x_pos), 31);
`else
    chk("x_low_limit", 32'(x_pos), 0);
`endif

    reset = 1'b1; tick(); reset = 1'b0;
    right_x = 1'b1; tick(); right_x = 1'b0; repeat (2) tick();
    chk("setup_x16", 32'(x_pos), 16);

    // aim axis and vector
    left_aim = 1'b1; tick(); left_aim = 1'b0; repeat (2) tick();
    chk("aim3", 32'(aim_pos), 3);
    chk("aim3_run", 32'(run), 4);
    chk("aim3_rise", 32'(rise), 16);
    chk("aim3_dir", 32'(dir), 0);
    right_aim = 1'b1; repeat (30) tick(); right_aim = 1'b0; repeat (2) tick();
    chk("aim7", 32'(aim_pos), 7);
    chk("aim7_run", 32'(run), 16);
    chk("aim7_rise", 32'(rise), 4);
    chk("aim7_dir", 32'(dir), 1);
    right_aim = 1'b1; tick(); right_aim = 1'b0; repeat (2) tick();
    chk("aim_sat", 32'(aim_pos), 7);
    for (int i = 0; i < 2; i++) begin
      left_aim = 1'b1; tick(); left_aim = 1'b0; repeat (2) tick();
    end
    chk("aim5", 32'(aim_pos), 5);
    chk("aim5_run", 32'(run), 8);
    chk("aim5_rise", 32'(rise), 12);

    // fire and handshake
    fire = 1'b1; tick(); fire = 1'b0;
    chk("fire_lat", 32'(shot_valid), 0);
    tick();
    chk("fire_valid", 32'(shot_valid), 1);
    chk("fire_x", 32'(shot_x), 16);
    chk("fire_aim", 32'(shot_aim), 5);
    right_x = 1'b1; tick(); right_x = 1'b0; repeat (2) tick();
    chk("move_while_pending", 32'(x_pos), 17);
    fire = 1'b1; tick(); fire = 1'b0; repeat (2) tick();
    chk("refire_valid", 32'(shot_valid), 1);
    chk("refire_x_held", 32'(shot_x), 16);
    chk("refire_aim_held", 32'(shot_aim), 5);
    shot_ready = 1'b1; tick(); shot_ready = 1'b0;
    chk("xfer_clear", 32'(shot_valid), 0);
    shot_ready = 1'b1; repeat (3) tick(); shot_ready = 1'b0;
    chk("ready_alone", 32'(shot_valid), 0);
    fire = 1'b1; tick(); fire = 1'b0; tick();
    chk("fire2_valid", 32'(shot_valid), 1);
    chk("fire2_x", 32'(shot_x), 17);
    fire = 1'b1; tick(); shot_ready = 1'b1; fire = 1'b0; tick(); shot_ready = 1'b0;
    chk("xfer_drop_clear", 32'(shot_valid), 0);
    tick();
    chk("xfer_drop_press", 32'(shot_valid), 0);

    // both x buttons held, then right released while left stays down
    left_x = 1'b1; right_x = 1'b1; repeat (20) tick();
    chk("both_held", 32'(x_pos), 17);
    right_x = 1'b0; tick();
    chk("release_edge1", 32'(x_pos), 17);
    tick();
    chk("release_edge2", 32'(x_pos), 16);
    repeat (7) tick();
    chk("restart_cnt7", 32'(x_pos), 16);
    tick();
    chk("restart_cnt8", 32'(x_pos), 15);
    left_x = 1'b0; repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
